// File: rtl/uart_rx_pkt.sv
// uart_rx_pkt: bus-side consumer of uart_rx. Polls the uart_rx control
// register, pops bytes from its rx FIFO and parses framed packets
// [SYNC, LEN, LEN payload bytes, CHK]. CHK is XOR of LEN and the payload.
// Good payloads are replayed as a valid/ready byte stream. Bad packets are
// dropped and reported with a one-cycle error pulse.
// Ports:
//   clk, reset (async, active-low)
//   rx_addr/rx_rden/rx_wren/rx_din -> uart_rx register port
//     (3'b111 control, 3'b101 rx_reg)
//   rx_dout <- uart_rx read data (combinational read)
//   pkt_data/pkt_valid/pkt_last/pkt_ready -> payload stream
//   pkt_err/err_code -> error pulse and code
//     (1 frame, 2 length, 3 checksum, 4 timeout, 5 overrun)
//   busy -> a packet is in progress or draining
module uart_rx_pkt #(
  parameter int unsigned MAX_LEN = 16,
  parameter logic [7:0]  SYNC    = 8'hA5,
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       reset,
  output logic [2:0] rx_addr,
  output logic       rx_rden,
  output logic       rx_wren,
  output logic [7:0] rx_din,
  input  logic [8:0] rx_dout,
  output logic [7:0] pkt_data,
  output logic       pkt_valid,
  output logic       pkt_last,
  input  logic       pkt_ready,
  output logic       pkt_err,
  output logic [2:0] err_code,
  output logic       busy
);

  localparam int unsigned IW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]  MAX_B   = 8'(MAX_LEN);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_INIT, S_POLL, S_POP, S_CAPTURE, S_SETTLE, S_DRAIN, S_RECOVER
  } bus_t;
  typedef enum logic [1:0] {P_HUNT, P_LEN, P_PAYLOAD, P_CHK} prs_t;

  bus_t        state_q, state_d;
  prs_t        pstate_q, pstate_d;
  logic        armed_q;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  chk_q, chk_d;
  logic [7:0]  didx_q, didx_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic        done_q, done_d;
  logic        err_d;
  logic [2:0]  code_d;
  logic        timed_out;
  logic        buf_we;
  logic [7:0]  pbuf [MAX_LEN];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_INIT;
      pstate_q <= P_HUNT;
      armed_q  <= 1'b0;
      cnt_q    <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      chk_q    <= '0;
      didx_q   <= '0;
      tcnt_q   <= '0;
      done_q   <= 1'b0;
      pkt_err  <= 1'b0;
      err_code <= '0;
    end else begin
      state_q  <= state_d;
      pstate_q <= pstate_d;
      armed_q  <= 1'b1;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      chk_q    <= chk_d;
      didx_q   <= didx_d;
      tcnt_q   <= tcnt_d;
      done_q   <= done_d;
      pkt_err  <= err_d;
      err_code <= code_d;
    end
  end

  // Payload storage is never reset: a reset abandons it and done_q gates reuse.
  always_ff @(posedge clk) begin
    if (buf_we) pbuf[idx_q[IW-1:0]] <= rx_dout[7:0];
  end

  always_comb begin
    state_d  = state_q;
    pstate_d = pstate_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    idx_d    = idx_q;
    chk_d    = chk_q;
    didx_d   = didx_q;
    done_d   = done_q;
    tcnt_d   = '0;
    err_d    = 1'b0;
    code_d   = err_code;
    buf_we   = 1'b0;
    rx_addr  = 3'b111;
    rx_rden  = 1'b0;
    rx_wren  = 1'b0;
    rx_din   = '0;

    // Inter-byte timeout; a completed packet waiting to drain is exempt.
    timed_out = 1'b0;
    if (pstate_q != P_HUNT && !done_q) begin
      if (tcnt_q == TO_LAST) timed_out = 1'b1;
      else tcnt_d = tcnt_q + 16'd1;
    end
    if (timed_out) begin
      pstate_d = P_HUNT;
      err_d    = 1'b1;
      code_d   = 3'd4;
    end

    case (state_q)
      // armed_q holds INIT idle for the first cycle so outputs stay 0 in reset.
      S_INIT: begin
        if (armed_q) begin
          rx_wren = 1'b1;
          rx_din  = 8'h01;
          state_d = S_POLL;
        end
      end
      S_POLL: begin
        rx_rden = 1'b1;
        if (rx_dout[2]) begin
          state_d  = S_RECOVER;
          cnt_d    = '0;
          pstate_d = P_HUNT;
          done_d   = 1'b0;
          err_d    = 1'b1;
          code_d   = 3'd5;
        end else if (rx_dout[1]) begin
          state_d = S_POP;
        end
      end
      S_POP: begin
        rx_rden = 1'b1;
        rx_addr = 3'b101;
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        rx_addr = 3'b101;
        tcnt_d  = '0;
        state_d = S_SETTLE;
        cnt_d   = '0;
        if (rx_dout[8]) begin
          pstate_d = P_HUNT;
          err_d    = 1'b1;
          code_d   = 3'd1;
        end else if (!timed_out) begin
          case (pstate_q)
            P_HUNT: if (rx_dout[7:0] == SYNC) pstate_d = P_LEN;
            P_LEN: begin
              if (rx_dout[7:0] == 8'd0 || rx_dout[7:0] > MAX_B) begin
                pstate_d = P_HUNT;
                err_d    = 1'b1;
                code_d   = 3'd2;
              end else begin
                len_d    = rx_dout[7:0];
                chk_d    = rx_dout[7:0];
                idx_d    = '0;
                pstate_d = P_PAYLOAD;
              end
            end
            P_PAYLOAD: begin
              buf_we = 1'b1;
              chk_d  = chk_q ^ rx_dout[7:0];
              idx_d  = idx_q + 8'd1;
              if (idx_q + 8'd1 == len_q) pstate_d = P_CHK;
            end
            default: begin
              if (rx_dout[7:0] == chk_q) begin
                done_d = 1'b1;
              end else begin
                pstate_d = P_HUNT;
                err_d    = 1'b1;
                code_d   = 3'd3;
              end
            end
          endcase
        end
      end
      S_SETTLE: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd1) begin
          state_d = done_q ? S_DRAIN : S_POLL;
          didx_d  = '0;
        end
      end
      S_DRAIN: begin
        if (pkt_ready) begin
          if (didx_q == len_q - 8'd1) begin
            state_d  = S_POLL;
            pstate_d = P_HUNT;
            done_d   = 1'b0;
          end else begin
            didx_d = didx_q + 8'd1;
          end
        end
      end
      default: begin
        // RECOVER: drop RXEN, hold it off two cycles, then re-enable.
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd0) begin
          rx_wren = 1'b1;
          rx_din  = 8'h00;
        end else if (cnt_q == 2'd3) begin
          rx_wren = 1'b1;
          rx_din  = 8'h01;
          state_d = S_POLL;
        end
      end
    endcase
  end

  assign pkt_valid = (state_q == S_DRAIN);
  assign pkt_data  = pkt_valid ? pbuf[didx_q[IW-1:0]] : '0;
  assign pkt_last  = pkt_valid && (didx_q == len_q - 8'd1);
  assign busy      = (pstate_q != P_HUNT);

endmodule
